// File: rtl/reg_wb_arbiter.sv
// Register-file write-back arbiter: merges single-cycle ALU results and buffered
// long-latency responses onto the single write port, and tracks outstanding
// long-latency destinations in a busy scoreboard for ID hazard stalls.
module reg_wb_arbiter #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned CNT_W      = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ex_wen_i,
    input  logic [4:0]  ex_waddr_i,
    input  logic [31:0] ex_wdata_i,
    output logic        ex_hold_o,

    input  logic        lsu_issue_i,
    input  logic [4:0]  lsu_issue_rd_i,
    input  logic        lsu_rsp_valid_i,
    input  logic [4:0]  lsu_rsp_rd_i,
    input  logic [31:0] lsu_rsp_data_i,
    output logic        lsu_rsp_ready_o,

    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic [4:0]  id_rd_i,
    output logic        id_stall_o,

    output logic        reg_wen_o,
    output logic [4:0]  reg_waddr_o,
    output logic [31:0] reg_wdata_o,
    output logic [31:0] busy_o
);

    localparam int unsigned      PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [4:0]       fifo_rd_q   [FIFO_DEPTH];
    logic [31:0]      fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [CNT_W-1:0] count_q;
    logic [31:0]      busy_q;
    logic [31:0]      busy_d;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [4:0]       head_rd;
    logic [31:0]      head_data;

    // FIFO status and handshake decode; ALU always wins the write port.
    always_comb begin
        full            = (count_q == FULL_CNT);
        empty           = (count_q == '0);
        push            = lsu_rsp_valid_i & ~full;
        pop             = ~ex_wen_i & ~empty;
        head_rd         = fifo_rd_q[rptr_q];
        head_data       = fifo_data_q[rptr_q];
        ex_hold_o       = full;
        lsu_rsp_ready_o = ~full;
        id_stall_o      = busy_q[id_rs1_i] | busy_q[id_rs2_i] | busy_q[id_rd_i];
        busy_o          = busy_q;
    end

    // Scoreboard next state: pop clears, issue sets afterwards so set wins on a tie.
    always_comb begin
        busy_d = busy_q;
        if (pop) begin
            busy_d[head_rd] = 1'b0;
        end
        if (lsu_issue_i && (lsu_issue_rd_i != 5'd0)) begin
            busy_d[lsu_issue_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Response FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_rd_q[i]   <= 5'd0;
                fifo_data_q[i] <= 32'd0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                fifo_rd_q[wptr_q]   <= lsu_rsp_rd_i;
                fifo_data_q[wptr_q] <= lsu_rsp_data_i;
                wptr_q              <= wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Busy scoreboard register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= 32'd0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Write-port register: ALU first, then FIFO head; idle holds address and data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_wen_o   <= 1'b0;
            reg_waddr_o <= 5'd0;
            reg_wdata_o <= 32'd0;
        end else if (ex_wen_i) begin
            reg_wen_o   <= (ex_waddr_i != 5'd0);
            reg_waddr_o <= ex_waddr_i;
            reg_wdata_o <= ex_wdata_i;
        end else if (pop) begin
            reg_wen_o   <= (head_rd != 5'd0);
            reg_waddr_o <= head_rd;
            reg_wdata_o <= head_data;
        end else begin
            reg_wen_o   <= 1'b0;
        end
    end

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Writer-side companion of the register file: owns its single write port (waddr/wdata/wen) and merges two result sources into it.
- Source 1: single-cycle ALU results from EX.
- Source 2: long-latency load/divide responses, buffered in a small FIFO.
- Also keeps a 32-entry busy scoreboard for outstanding long-latency destinations and gives ID a stall signal for RAW/WAW hazards.

Parameters:
FIFO_DEPTH, 2, long-latency response buffer entries; power of two, >=2
CNT_W, 2, FIFO occupancy counter width, equal to log2(FIFO_DEPTH)+1

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-low reset
ex_wen_i  input  1  ALU result valid this cycle
ex_waddr_i  input  5  ALU destination register
ex_wdata_i  input  32  ALU result
ex_hold_o  output  1  freeze-EX request to ctrl; equals FIFO full (combinational)
lsu_issue_i  input  1  long-latency op issued this cycle
lsu_issue_rd_i  input  5  destination of issued op
lsu_rsp_valid_i  input  1  long-latency result valid
lsu_rsp_rd_i  input  5  result destination
lsu_rsp_data_i  input  32  result data
lsu_rsp_ready_o  output  1  equals !FIFO full
id_rs1_i  input  5  ID source 1 address
id_rs2_i  input  5  ID source 2 address
id_rd_i  input  5  ID destination address
id_stall_o  output  1  combinational: busy[rs1] | busy[rs2] | busy[rd]
reg_wen_o  output  1  register-file write enable (registered)
reg_waddr_o  output  5  register-file write address (registered)
reg_wdata_o  output  32  register-file write data (registered)
busy_o  output  32  scoreboard bits, bit 0 always 0

Behaviour:
- Reset (rst=0, async, any cycle including mid-drain):
  - reg_wen_o=0, reg_waddr_o=0, reg_wdata_o=0.
  - FIFO empty (pointers and count = 0), busy_o=0.
  - Outputs ex_hold_o=0, lsu_rsp_ready_o=1, id_stall_o=0.
  - In-flight responses are discarded.
- FIFO push: lsu_rsp_valid_i & lsu_rsp_ready_o at the edge stores {rd, data}.
- Output register, loaded every edge, priority order:
  1. ex_wen_i=1: load the ALU write; reg_wen_o = (ex_waddr_i!=0). The FIFO head stays.
  2. else FIFO non-empty: pop the head; reg_wen_o = (head rd != 0).
  3. else reg_wen_o=0; waddr and wdata hold their previous values.
- Latency:
  - ALU write: reg_wen_o high in the cycle after ex_wen_i.
  - Response accepted at edge N: earliest reg_wen_o is the cycle after edge N+1, i.e. 2 cycles.
- Simultaneous push and pop in one cycle is allowed; count unchanged. Push is only blocked by full, never by a pop.
- Pointers wrap modulo FIFO_DEPTH. Count saturates logically at FIFO_DEPTH, which is exactly the full condition.
- ex_hold_o=1 whenever the FIFO is full. Ctrl guarantees ex_wen_i=0 while ex_hold_o=1, so the FIFO drains one entry per cycle. ex_wen_i=1 with ex_hold_o=1 is a protocol violation: bench asserts it; RTL still gives ALU priority.
- Scoreboard:
  - lsu_issue_i with rd!=0 sets busy[rd] at the edge.
  - A FIFO pop of rd clears busy[rd] on the same edge that loads reg_wen_o. During the following cycle, the register file's same-cycle bypass supplies the data, so id_stall_o may drop in that cycle.
  - Set and clear of the same rd on one edge: set wins.
  - Issue to rd=0 is ignored. busy_o[0] is hard 0.
- ALU write to an rd with busy=1 is a protocol violation (ID stalls WAW): bench asserts it; RTL writes anyway and leaves busy unchanged.

Test Plan:
1. Reset mid-drain: FIFO holds 2 entries and busy[5]=1, then rst pulses low between edges -> outputs immediately reg_wen_o=0, busy_o=0, lsu_rsp_ready_o=1, FIFO empty after release.
2. ALU only: ex_wen_i=1, waddr=3, wdata=0xDEADBEEF -> next cycle reg_wen_o=1, reg_waddr_o=3, reg_wdata_o=0xDEADBEEF; waddr=0 instead -> reg_wen_o=0.
3. Scoreboard: issue rd=7, id_rs1_i=7 -> id_stall_o=1; response rd=7, data 0x12 accepted at edge N -> reg_wen_o=1 with waddr 7 and data 0x12 in the cycle after edge N+1, with busy[7]=0 and id_stall_o=0 in that same cycle.
4. Collision: response rd=9 accepted while ex_wen_i held high for 3 cycles -> ALU writes appear first, then rd=9 is written the cycle after ex_wen_i drops; busy[9] stays set until then.
5. Full/backpressure, FIFO_DEPTH=2: push 2 responses while ALU is busy -> lsu_rsp_ready_o=0 and ex_hold_o=1; ALU idles -> entries drain in order and ready returns high after the first pop; a third valid held during full is accepted only afterwards.
6. Same-edge set/clear: pop of rd=4 coincides with a new issue to rd=4 -> reg_wen_o writes rd 4 and busy[4] remains 1.
